// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared constants for the SPI slave core
// Contents: status flag bit positions, SPI mode encodings as {CPOL, CPHA}.
package spi_slave_pkg;

    localparam int ST_UNDERRUN = 0;
    localparam int ST_OVERRUN  = 1;
    localparam int ST_PARTIAL  = 2;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulse outputs
// Ports: clk_sys, rst_n (async active-low), d (async input),
//        q (synchronised level), rise/fall (1-cycle pulses on q transitions).
module spi_sync_edge #(
    parameter int STAGES  = 3,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - parametrised SPI slave with TX/RX handshakes and frame status
// Ports: clk_sys, rst_n (async active-low); spi_clk/spi_mosi/spi_cs_n pins in;
//        spi_miso/spi_miso_oe out; tx_data/tx_valid/tx_ready holding-register
//        handshake; rx_data/rx_valid/rx_ready receive handshake; frame_start,
//        frame_end pulses; word_cnt; sticky status with status_clr; busy.
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int                SYNC_STAGES = 3,
    parameter int                CNT_W       = 16,
    parameter logic [DATA_W-1:0] TX_FILL     = '1
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [2:0]        status,
    input  logic              status_clr,
    output logic              busy
);

    localparam logic [1:0]    MODE           = {CPOL, CPHA};
    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling.
    localparam bit            SAMPLE_ON_RISE = (MODE == MODE0) || (MODE == MODE3);
    localparam int            BW             = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST           = BW'(DATA_W - 1);

    logic       unused_sclk_level;
    logic [1:0] unused_mosi_edges;
    logic       sclk_rise, sclk_fall;
    logic       cs_n_s, cs_deassert, cs_assert;
    logic       mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk_sys(clk_sys), .rst_n(rst_n), .d(spi_clk),
        .q(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CS chain resets to "asserted" so a CS that is already low when reset
    // releases produces no edge; a real high must be seen before a frame starts.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk_sys(clk_sys), .rst_n(rst_n), .d(spi_cs_n),
        .q(cs_n_s), .rise(cs_deassert), .fall(cs_assert)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_sys(clk_sys), .rst_n(rst_n), .d(spi_mosi),
        .q(mosi_s), .rise(unused_mosi_edges[1]), .fall(unused_mosi_edges[0])
    );

    logic [DATA_W-1:0] hold_q, hold_d, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [2:0]        status_q, status_d;
    logic              in_frame_q, in_frame_d, armed_q, armed_d;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              frame_start_w, frame_end_w, sample_edge, shift_edge, load_evt;

    assign frame_start_w = cs_assert & armed_q & ~in_frame_q;
    assign frame_end_w   = cs_deassert & in_frame_q;
    assign sample_edge   = in_frame_q & (SAMPLE_ON_RISE ? sclk_rise : sclk_fall);
    assign shift_edge    = in_frame_q & (SAMPLE_ON_RISE ? sclk_fall : sclk_rise);

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        in_frame_d  = in_frame_q;
        armed_d     = armed_q | cs_n_s;
        oe_d        = in_frame_q;
        status_d    = status_clr ? 3'b000 : status_q;
        load_evt    = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        // Only accepted while empty, so it can never collide with a load
        // that drains a full register.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (frame_start_w) begin
            in_frame_d = 1'b1;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            load_evt   = !CPHA;
        end else if (frame_end_w) begin
            in_frame_d = 1'b0;
            if (bit_cnt_q != '0) status_d[ST_PARTIAL] = 1'b1;
            bit_cnt_d  = '0;
        end else if (sample_edge) begin
            rx_shift_d = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_s}
                                   : {mosi_s, rx_shift_q[DATA_W-1:1]};
            if (bit_cnt_q == LAST) begin
                bit_cnt_d  = '0;
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ready) status_d[ST_OVERRUN] = 1'b1;
                if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (shift_edge) begin
            // A zero bit count on a shift edge marks a word boundary in both
            // phases: after the last sample (CPHA=0) or before the first (CPHA=1).
            if (bit_cnt_q == '0) begin
                load_evt = 1'b1;
            end else begin
                tx_shift_d = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                       : {1'b0, tx_shift_q[DATA_W-1:1]};
            end
        end

        // Uses hold_full_q, so a handshake in this same cycle feeds the next word.
        if (load_evt) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d            = TX_FILL;
                status_d[ST_UNDERRUN] = 1'b1;
            end
        end

        // Taken from the next shift value so MISO moves one clock after the event.
        miso_d = MSB_FIRST ? tx_shift_d[DATA_W-1] : tx_shift_d[0];
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            status_q    <= 3'b000;
            in_frame_q  <= 1'b0;
            armed_q     <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            status_q    <= status_d;
            in_frame_q  <= in_frame_d;
            armed_q     <= armed_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_w;
    assign frame_end   = frame_end_w;
    assign word_cnt    = word_cnt_q;
    assign status      = status_q;
    assign busy        = in_frame_q;

endmodule
